// File: rtl/coh_directory.sv
// coh_directory: MSI directory controller for N private L1 caches.
// Round-robin request arbitration, snoop issue/collect, grant return.
module coh_directory #(
  parameter int NUM_CACHES = 4,
  parameter int ADDR_W = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [NUM_CACHES-1:0] req_valid,
  input  logic [2*NUM_CACHES-1:0] req_op,
  input  logic [NUM_CACHES*ADDR_W-1:0] req_addr,
  output logic [NUM_CACHES-1:0] req_ready,
  output logic [NUM_CACHES-1:0] snp_valid,
  output logic snp_downgrade,
  output logic [ADDR_W-1:0] snp_addr,
  input  logic [NUM_CACHES-1:0] snp_ack,
  output logic [NUM_CACHES-1:0] resp_valid,
  output logic resp_excl,
  output logic [ADDR_W-1:0] resp_addr,
  output logic busy
);

  localparam int N = NUM_CACHES;
  localparam int PW = $clog2(NUM_CACHES);
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] LINE_I = 2'b00;
  localparam logic [1:0] LINE_S = 2'b01;
  localparam logic [1:0] LINE_M = 2'b10;

  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_EV = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    SNOOP,
    RESP
  } fsm_e;

  fsm_e state;
  fsm_e stateNext;

  logic [PW-1:0] rrPtr;
  logic [PW-1:0] rrNext;
  logic [PW:0] rrSum;
  logic [PW-1:0] rrIdx;
  logic [PW-1:0] grant;
  logic grantFound;
  logic [PW-1:0] grantQ;

  logic [1:0] opSel;
  logic [ADDR_W-1:0] addrSel;
  logic [1:0] opQ;
  logic [ADDR_W-1:0] addrQ;

  logic [N-1:0] pending;
  logic [N-1:0] pendingNext;
  logic [N-1:0] target;
  logic [N-1:0] gBit;

  logic [1:0] dirState [DEPTH];
  logic [N-1:0] dirSharers [DEPTH];

  logic [1:0] curState;
  logic [N-1:0] curSharers;
  logic [1:0] newState;
  logic [N-1:0] newSharers;
  logic respExcl;

  // Round-robin pick: first valid requester at or after rrPtr.
  always_comb begin
    grant = rrPtr;
    grantFound = 1'b0;
    rrSum = '0;
    rrIdx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      rrSum = {1'b0, rrPtr} + (PW+1)'(k);
      if (rrSum >= (PW+1)'(N))
        rrSum = rrSum - (PW+1)'(N);
      rrIdx = rrSum[PW-1:0];
      if (req_valid[rrIdx]) begin
        grant = rrIdx;
        grantFound = 1'b1;
      end
    end
    rrNext = (grant == PW'(N - 1)) ? '0 : grant + PW'(1);
  end

  // Mux the winner's op and address out of the packed request buses.
  always_comb begin
    opSel = OP_NOP;
    addrSel = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == PW'(i)) begin
        opSel = req_op[2*i +: 2];
        addrSel = req_addr[ADDR_W*i +: ADDR_W];
      end
    end
  end

  // Current entry, snoop targets and the entry update for this request.
  always_comb begin
    gBit = '0;
    gBit[grantQ] = 1'b1;
    curState = dirState[addrQ];
    curSharers = dirSharers[addrQ];
    target = '0;
    newState = curState;
    newSharers = curSharers;
    respExcl = 1'b0;
    case (opQ)
      OP_RD: begin
        if (curState == LINE_M && curSharers != gBit)
          target = curSharers;
        if (curState == LINE_M && curSharers == gBit) begin
          respExcl = 1'b1;
        end else begin
          newState = LINE_S;
          newSharers = curSharers | gBit;
        end
      end
      OP_WR: begin
        target = curSharers & ~gBit;
        newState = LINE_M;
        newSharers = gBit;
        respExcl = 1'b1;
      end
      OP_EV: begin
        newSharers = curSharers & ~gBit;
        if (newSharers == '0)
          newState = LINE_I;
      end
      default: ;
    endcase
  end

  // Next-state logic and all handshake outputs.
  always_comb begin
    stateNext = state;
    pendingNext = pending;
    req_ready = '0;
    snp_valid = '0;
    snp_downgrade = 1'b0;
    resp_valid = '0;
    resp_excl = 1'b0;
    busy = (state != IDLE);
    case (state)
      IDLE: begin
        if (grantFound && rst_n) begin
          req_ready[grant] = 1'b1;
          stateNext = LOOKUP;
        end
      end
      LOOKUP: begin
        if (target != '0) begin
          pendingNext = target;
          stateNext = SNOOP;
        end else begin
          stateNext = RESP;
        end
      end
      SNOOP: begin
        snp_valid = pending;
        snp_downgrade = (opQ == OP_RD);
        pendingNext = pending & ~snp_ack;
        if (pendingNext == '0)
          stateNext = RESP;
      end
      RESP: begin
        resp_valid[grantQ] = 1'b1;
        resp_excl = respExcl;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign snp_addr = addrQ;
  assign resp_addr = addrQ;

  // FSM state and outstanding-snoop mask.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pending <= '0;
    end else begin
      state <= stateNext;
      pending <= pendingNext;
    end
  end

  // Latch the accepted request and advance the round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rrPtr <= '0;
      grantQ <= '0;
      opQ <= OP_NOP;
      addrQ <= '0;
    end else if (state == IDLE && grantFound) begin
      rrPtr <= rrNext;
      grantQ <= grant;
      opQ <= opSel;
      addrQ <= addrSel;
    end
  end

  // Directory entries; written once per transaction in RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        dirState[i] <= LINE_I;
        dirSharers[i] <= '0;
      end
    end else if (state == RESP) begin
      dirState[addrQ] <= newState;
      dirSharers[addrQ] <= newSharers;
    end
  end

endmodule

// File: tb/tb_coh_directory.sv
// tb_coh_directory: directed scenario tests for coh_directory.
// Directory contents are probed through later snoop behaviour.
module tb_coh_directory;

  localparam logic [1:0] RD = 2'b00;
  localparam logic [1:0] WR = 2'b01;
  localparam logic [1:0] EV = 2'b10;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req_valid;
  logic [7:0] req_op;
  logic [23:0] req_addr;
  logic [3:0] req_ready;
  logic [3:0] snp_valid;
  logic snp_downgrade;
  logic [5:0] snp_addr;
  logic [3:0] snp_ack;
  logic [3:0] resp_valid;
  logic resp_excl;
  logic [5:0] resp_addr;
  logic busy;

  int total = 0;
  int bad = 0;

  int oAcc;
  int oResp;
  logic [3:0] oSnp;
  logic oDg;
  logic [5:0] oSAddr;
  logic [3:0] oRespMask;
  logic oExcl;
  logic [5:0] oRAddr;

  coh_directory #(.NUM_CACHES(4), .ADDR_W(6)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_op(req_op),
    .req_addr(req_addr),
    .req_ready(req_ready),
    .snp_valid(snp_valid),
    .snp_downgrade(snp_downgrade),
    .snp_addr(snp_addr),
    .snp_ack(snp_ack),
    .resp_valid(resp_valid),
    .resp_excl(resp_excl),
    .resp_addr(resp_addr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // One transaction from cache c; acks come from ackSeq nibbles.
  task automatic runTxn(input int c, input logic [1:0] op,
                        input logic [5:0] a, input int nAck,
                        input logic [15:0] ackSeq);
    int k;
    logic seen;
    k = 0;
    seen = 1'b0;
    oAcc = -1;
    oResp = -1;
    oSnp = '0;
    oDg = 1'b0;
    oSAddr = '0;
    oRespMask = '0;
    oExcl = 1'b0;
    oRAddr = '0;
    @(negedge clk);
    req_valid[c] = 1'b1;
    req_op[2*c +: 2] = op;
    req_addr[6*c +: 6] = a;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (oAcc < 0) begin
        if (req_ready[c]) oAcc = n;
      end else begin
        if (snp_valid != 0 && !seen) begin
          seen = 1'b1;
          oSnp = snp_valid;
          oDg = snp_downgrade;
          oSAddr = snp_addr;
        end
        snp_ack = '0;
        if (snp_valid != 0 && k < nAck) begin
          snp_ack = ackSeq[4*k +: 4];
          k++;
        end
        if (resp_valid != 0) begin
          oResp = n - oAcc;
          oRespMask = resp_valid;
          oExcl = resp_excl;
          oRAddr = resp_addr;
        end
      end
      if (oResp >= 0) break;
      @(negedge clk);
      if (oAcc >= 0) req_valid[c] = 1'b0;
    end
    snp_ack = '0;
    req_valid[c] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'hF;
    req_op = 8'hFF;
    req_addr = '0;
    snp_ack = '0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (req_ready !== 4'h0) begin
      bad++;
      $display("FAIL rst_ready got=%h exp=0", req_ready);
    end
    total++;
    if ({snp_valid, resp_valid, resp_excl, snp_downgrade, busy} !== 11'h0) begin
      bad++;
      $display("FAIL rst_outs got=%h/%h/%b/%b/%b exp=0",
               snp_valid, resp_valid, resp_excl, snp_downgrade, busy);
    end
    total++;
    if ({snp_addr, resp_addr} !== 12'h0) begin
      bad++;
      $display("FAIL rst_addr got=%h/%h exp=0", snp_addr, resp_addr);
    end
    req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_read_miss();
    runTxn(0, RD, 6'h05, 0, 16'h0);
    total++;
    if (oAcc !== 0) begin
      bad++;
      $display("FAIL rd_acc got=%0d exp=0", oAcc);
    end
    total++;
    if (oResp !== 2) begin
      bad++;
      $display("FAIL rd_lat got=%0d exp=2", oResp);
    end
    total++;
    if ({oRespMask, oExcl, oSnp} !== {4'b0001, 1'b0, 4'b0000}) begin
      bad++;
      $display("FAIL rd_resp got=%b/%b/%b exp=0001/0/0000",
               oRespMask, oExcl, oSnp);
    end
    total++;
    if (oRAddr !== 6'h05) begin
      bad++;
      $display("FAIL rd_addr got=%h exp=05", oRAddr);
    end
  endtask

  task automatic test_write_invalidate();
    runTxn(1, RD, 6'h05, 0, 16'h0);
    total++;
    if (oResp !== 2 || oSnp !== 4'b0000) begin
      bad++;
      $display("FAIL rd1 got=%0d/%b exp=2/0000", oResp, oSnp);
    end
    runTxn(2, RD, 6'h05, 0, 16'h0);
    total++;
    if (oResp !== 2 || oSnp !== 4'b0000) begin
      bad++;
      $display("FAIL rd2 got=%0d/%b exp=2/0000", oResp, oSnp);
    end
    runTxn(3, WR, 6'h05, 3, 16'h0412);
    total++;
    if (oSnp !== 4'b0111 || oDg !== 1'b0) begin
      bad++;
      $display("FAIL wr_snp got=%b/%b exp=0111/0", oSnp, oDg);
    end
    total++;
    if (oSAddr !== 6'h05) begin
      bad++;
      $display("FAIL wr_saddr got=%h exp=05", oSAddr);
    end
    total++;
    if (oResp !== 5) begin
      bad++;
      $display("FAIL wr_lat got=%0d exp=5", oResp);
    end
    total++;
    if (oRespMask !== 4'b1000 || oExcl !== 1'b1) begin
      bad++;
      $display("FAIL wr_resp got=%b/%b exp=1000/1", oRespMask, oExcl);
    end
  endtask

  task automatic test_downgrade();
    runTxn(1, RD, 6'h05, 2, 16'h0081);
    total++;
    if (oSnp !== 4'b1000 || oDg !== 1'b1) begin
      bad++;
      $display("FAIL dg_snp got=%b/%b exp=1000/1", oSnp, oDg);
    end
    total++;
    if (oResp !== 4) begin
      bad++;
      $display("FAIL dg_lat got=%0d exp=4", oResp);
    end
    total++;
    if (oRespMask !== 4'b0010 || oExcl !== 1'b0) begin
      bad++;
      $display("FAIL dg_resp got=%b/%b exp=0010/0", oRespMask, oExcl);
    end
    runTxn(0, WR, 6'h05, 1, 16'h000A);
    total++;
    if (oSnp !== 4'b1010 || oDg !== 1'b0) begin
      bad++;
      $display("FAIL sh_snp got=%b/%b exp=1010/0", oSnp, oDg);
    end
    total++;
    if (oResp !== 3 || oExcl !== 1'b1) begin
      bad++;
      $display("FAIL sh_resp got=%0d/%b exp=3/1", oResp, oExcl);
    end
    runTxn(0, RD, 6'h05, 0, 16'h0);
    total++;
    if (oSnp !== 4'b0000 || oResp !== 2 || oExcl !== 1'b1) begin
      bad++;
      $display("FAIL own_rd got=%b/%0d/%b exp=0000/2/1",
               oSnp, oResp, oExcl);
    end
  endtask

  task automatic test_evict();
    runTxn(2, WR, 6'h3F, 0, 16'h0);
    total++;
    if (oSnp !== 4'b0000 || oResp !== 2 || oExcl !== 1'b1) begin
      bad++;
      $display("FAIL ev_own got=%b/%0d/%b exp=0000/2/1",
               oSnp, oResp, oExcl);
    end
    runTxn(2, EV, 6'h3F, 0, 16'h0);
    total++;
    if (oSnp !== 4'b0000 || oResp !== 2) begin
      bad++;
      $display("FAIL ev_lat got=%b/%0d exp=0000/2", oSnp, oResp);
    end
    total++;
    if (oRespMask !== 4'b0100 || oExcl !== 1'b0) begin
      bad++;
      $display("FAIL ev_resp got=%b/%b exp=0100/0", oRespMask, oExcl);
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL ev_busy_resp got=%b exp=1", busy);
    end
    @(negedge clk);
    snp_ack = 4'hF;
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL ev_busy_after got=%b exp=0", busy);
    end
    @(negedge clk);
    snp_ack = '0;
    runTxn(1, WR, 6'h3F, 0, 16'h0);
    total++;
    if (oSnp !== 4'b0000 || oResp !== 2 || oAcc !== 0) begin
      bad++;
      $display("FAIL ev_inv got=%b/%0d/%0d exp=0000/2/0",
               oSnp, oResp, oAcc);
    end
  endtask

  task automatic test_round_robin();
    int gi;
    int gc [8];
    logic [3:0] gm [8];
    logic [3:0] e;
    gi = 0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'hF;
    req_op = 8'hFF;
    for (int n = 0; n < 15; n++) begin
      #1;
      if (req_ready != 0 && gi < 8) begin
        gc[gi] = n;
        gm[gi] = req_ready;
        gi++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    total++;
    if (gi !== 5) begin
      bad++;
      $display("FAIL rr_count got=%0d exp=5", gi);
    end
    for (int k = 0; k < 5 && k < gi; k++) begin
      e = 4'b0001 << (k % 4);
      total++;
      if (gc[k] !== 3 * k || gm[k] !== e) begin
        bad++;
        $display("FAIL rr_grant%0d got=%0d/%b exp=%0d/%b",
                 k, gc[k], gm[k], 3 * k, e);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic seenResp;
    runTxn(0, RD, 6'h05, 0, 16'h0);
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_op[3:2] = WR;
    req_addr[11:6] = 6'h05;
    #1;
    total++;
    if (req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL mr_acc got=%b exp=0010", req_ready);
    end
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (snp_valid !== 4'b0001) begin
      bad++;
      $display("FAIL mr_snp got=%b exp=0001", snp_valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (snp_valid !== 4'b0000 || resp_valid !== 4'b0000 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mr_drop got=%b/%b/%b exp=0000/0000/0",
               snp_valid, resp_valid, busy);
    end
    rst_n = 1'b1;
    seenResp = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (resp_valid != 0) seenResp = 1'b1;
    end
    total++;
    if (seenResp !== 1'b0) begin
      bad++;
      $display("FAIL mr_noresp got=%b exp=0", seenResp);
    end
    runTxn(2, WR, 6'h05, 0, 16'h0);
    total++;
    if (oSnp !== 4'b0000 || oResp !== 2 || oExcl !== 1'b1) begin
      bad++;
      $display("FAIL mr_entry got=%b/%0d/%b exp=0000/2/1",
               oSnp, oResp, oExcl);
    end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_write_invalidate();
    test_downgrade();
    test_evict();
    test_round_robin();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coh_directory.md
# coh_directory

Parametrised, stand-alone directory controller for an N-cache MSI coherence system, sitting between the private L1 caches and the shared L2/memory side. It arbitrates coherence requests from all L1s round-robin and tracks per-line state plus a sharer bit-vector for every line of a 2^ADDR_W address space. It issues invalidate/downgrade snoops, collects acknowledgements, and returns a grant to the requester. Data movement is outside this block; only control and directory state live here.

## Interface
- NUM_CACHES, 4, number of L1 requesters (N), 2..8
- ADDR_W, 6, line address width; directory holds 2^ADDR_W entries
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  N  request pending from cache i
- req_op  in  2N  per-cache op, bits [2i+1:2i]: 00 read, 01 write/upgrade, 10 evict, 11 no-op
- req_addr  in  N*ADDR_W  per-cache line address, bits [ADDR_W*i +: ADDR_W]
- req_ready  out  N  one-cycle accept pulse to granted cache
- snp_valid  out  N  snoop outstanding to cache i (level, held until acked)
- snp_downgrade  out  1  1 = downgrade M->S, 0 = invalidate
- snp_addr  out  ADDR_W  snooped line address
- snp_ack  in  N  one-cycle ack per cache
- resp_valid  out  N  one-cycle grant to requester
- resp_excl  out  1  1 = granted M, 0 = granted S or evict/no-op done
- resp_addr  out  ADDR_W  address of granted line
- busy  out  1  FSM not in IDLE

## Operation
- Entry: state (I=00, S=01, M=10) + N-bit sharers. Invariant: M => sharers one-hot (owner); I => sharers 0.
- FSM states: IDLE, LOOKUP, SNOOP, RESP.
- IDLE: if any req_valid, grant g = first requester at or after rr_ptr (wrapping mod N); pulse req_ready[g], latch op/addr, rr_ptr <= (g+1) mod N; -> LOOKUP. Else stay.
- LOOKUP: compute target mask T:
  - read: T = owner if state M and owner != g (downgrade), else 0.
  - write: T = sharers & ~(1<<g) (invalidate).
  - evict / no-op: T = 0.
  - T != 0 -> SNOOP with pending <= T; else -> RESP.
- SNOOP: snp_valid = pending; snp_addr = latched addr; snp_downgrade = 1 for read, 0 for write. snp_ack[i] clears pending[i]; acks to bits not pending ignored. pending == 0 (after update) -> RESP.
- RESP: pulse resp_valid[g]; update entry:
  - read: if state M and owner == g: unchanged, resp_excl=1. Else state S, sharers |= 1<<g (downgraded owner stays sharer), resp_excl=0.
  - write: state M, sharers = 1<<g, resp_excl=1.
  - evict: sharers &= ~(1<<g); becomes 0 -> state I, else keep state (M with owner evicting -> I). resp_excl=0.
  - no-op: no update, resp_excl=0.
  - -> IDLE.
- req_valid of non-granted caches is held by the caches; no queueing inside the block.

## Timing
- Reset (rst_n low at rising edge): FSM IDLE, rr_ptr 0, all entries I/sharers 0, pending 0; req_ready, snp_valid, resp_valid, resp_excl, snp_downgrade, busy all 0; snp_addr, resp_addr 0. Reset mid-transaction drops it: no resp_valid, snoops withdrawn next cycle.
- Accept at cycle T (req_ready), LOOKUP T+1, no-snoop resp_valid at T+2.
- Snoop path: snp_valid from T+2; last ack in cycle A -> resp_valid at A+1. Minimum (ack in T+2) -> resp at T+3.
- Ack arriving in the same cycle snp_valid first rises counts.
- New acceptance earliest the cycle after resp_valid; one transaction in flight.
- busy high from T+1 through resp cycle inclusive.

## Test plan
- After reset, cache 0 reads 0x05 -> req_ready[0] at T, resp_valid[0] at T+2, resp_excl=0; entry 0x05 = S, sharers 0001.
- Caches 0,1,2 read 0x05, then cache 3 writes 0x05 -> snp_valid=0111, snp_downgrade=0; ack 1,0,2 on separate cycles; resp_valid[3] one cycle after last ack, resp_excl=1; entry M, sharers 1000.
- Cache 3 owns 0x05 (M); cache 1 reads -> snp_valid=1000, snp_downgrade=1; after ack resp_valid[1], resp_excl=0; entry S, sharers 1010.
- All four req_valid continuously held, no-op ops -> grants cycle 0,1,2,3,0 each 3 cycles apart.
- Owner 2 evicts M line 0x3F -> no snoop, resp at T+2; entry I, sharers 0000; spurious snp_ack ignored, busy drops after resp.
- Assert rst_n low during SNOOP -> snp_valid 0 next cycle, no resp_valid, entry 0x05 back to I.
